// File: rtl/ninjakun_romloader.sv
// ninjakun_romloader: streams download bytes through a 4-entry FIFO into the NJ ROMs at a paced write rate.
module ninjakun_romloader #(
  parameter int ROM_BYTES = 131072,
  parameter int PACE = 2
) (
  input  logic        ROMCL,
  input  logic        RESET,
  input  logic        DL_START,
  input  logic        DL_VALID,
  input  logic [7:0]  DL_DATA,
  output logic        DL_READY,
  output logic [16:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  CSUM,
  output logic        OVERRUN
);
  localparam logic [17:0] RB = 18'(ROM_BYTES);
  localparam logic [17:0] RB_LAST = 18'(ROM_BYTES - 1);
  localparam logic [3:0] PACE_RELOAD = 4'(PACE - 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  state_t state, nxt;
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic [17:0] acc, wcnt;
  logic [3:0] pace;
  logic push, pop;
  always_ff @(posedge ROMCL or posedge RESET)
    if (RESET) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = DL_START ? S_LOAD : (pop && wcnt == RB_LAST) ? S_DONE : state;
  // cnt[2] set means all four entries are occupied
  always_comb begin
    BUSY = state == S_LOAD;
    DONE = state == S_DONE;
    DL_READY = BUSY & ~cnt[2] & (acc < RB) & ~DL_START;
    push = DL_READY & DL_VALID;
    pop = BUSY & (cnt != 3'd0) & (pace == 4'd0) & ~DL_START;
  end
  always_ff @(posedge ROMCL)
    if (push) mem[wp] <= DL_DATA;
  always_ff @(posedge ROMCL or posedge RESET)
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      acc <= '0;
      wcnt <= '0;
      pace <= '0;
      ROMAD <= '0;
      ROMDT <= '0;
      ROMEN <= 1'b0;
      CSUM <= '0;
      OVERRUN <= 1'b0;
    end else begin
      ROMEN <= pop;
      OVERRUN <= ~DL_START & (OVERRUN | (DONE & DL_VALID));
      pace <= pop ? PACE_RELOAD : (pace != 4'd0) ? pace - 4'd1 : pace;
      if (DL_START) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        acc <= '0;
        wcnt <= '0;
        ROMAD <= '0;
        CSUM <= '0;
      end else begin
        cnt <= cnt + 3'(push) - 3'(pop);
        if (push) begin
          wp <= wp + 2'd1;
          acc <= acc + 18'd1;
        end
        if (pop) begin
          ROMAD <= wcnt[16:0];
          ROMDT <= mem[rp];
          CSUM <= CSUM + mem[rp];
          rp <= rp + 2'd1;
          wcnt <= wcnt + 18'd1;
        end
      end
    end
endmodule

// File: tb/tb_ninjakun_romloader.sv
// tb_ninjakun_romloader: directed checks on three loader instances (4/1, 8/4 and 2/1 bytes/pace).
module tb_ninjakun_romloader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st [3];
  logic vl [3];
  logic [7:0] dd [3];
  logic rdy [3], en [3], bsy [3], dn [3], ovr [3];
  logic [16:0] ad [3];
  logic [7:0] dt [3], cs [3];
  int ncmp = 0, nbad = 0, cyc = 0;
  int nw [3];
  logic [16:0] lad [3][32];
  logic [7:0] ldt [3][32];
  int lcy [3][32];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g
    ninjakun_romloader #(.ROM_BYTES(k == 0 ? 4 : k == 1 ? 8 : 2), .PACE(k == 1 ? 4 : 1)) dut (
      .ROMCL(clk), .RESET(rst), .DL_START(st[k]), .DL_VALID(vl[k]), .DL_DATA(dd[k]),
      .DL_READY(rdy[k]), .ROMAD(ad[k]), .ROMDT(dt[k]), .ROMEN(en[k]), .BUSY(bsy[k]),
      .DONE(dn[k]), .CSUM(cs[k]), .OVERRUN(ovr[k]));
  end
  always @(posedge clk) cyc <= cyc + 1;
  // write log, sampled mid-cycle
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (en[k] === 1'b1 && nw[k] < 32) begin
        lad[k][nw[k]] = ad[k];
        ldt[k][nw[k]] = dt[k];
        lcy[k][nw[k]] = cyc;
        nw[k]++;
      end
  typedef struct {
    logic s, v;
    logic [7:0] d;
    logic rdy, en, busy, done;
    logic [16:0] ad;
    logic [7:0] dt, cs;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [63:0] outs(input int k);
    return {rdy[k], en[k], bsy[k], dn[k], ovr[k], ad[k], dt[k], cs[k]};
  endfunction
  task automatic wait_wr(input int k, input int target);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (nw[k] >= target) break;
    end
  endtask
  task automatic pulse_start(input int k);
    @(negedge clk);
    st[k] = 1'b1;
    vl[k] = 1'b0;
    @(negedge clk);
    st[k] = 1'b0;
  endtask
  initial begin
    int base, acc, lowq;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      vl[k] = 1'b0;
      dd[k] = 8'h00;
      nw[k] = 0;
    end
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00, 8'h00};
    tv[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 8'h00, 8'h00};
    tv[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 8'h00, 8'h00};
    tv[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 17'd0, 8'h11, 8'h11};
    tv[4] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 17'd1, 8'h22, 8'h33};
    tv[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 17'd2, 8'h33, 8'h66};
    tv[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'd3, 8'h44, 8'hAA};
    tv[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 17'd3, 8'h44, 8'hAA};
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_%0d", k), outs(k), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post_reset_%0d", k), outs(k), 64'd0);
    // basic load on the 4-byte, pace-1 instance
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      st[0] = tv[i].s;
      vl[0] = tv[i].v;
      dd[0] = tv[i].d;
      #1;
      chk($sformatf("basic[%0d]", i), {rdy[0], en[0], bsy[0], dn[0], ad[0], dt[0], cs[0]},
          {tv[i].rdy, tv[i].en, tv[i].busy, tv[i].done, tv[i].ad, tv[i].dt, tv[i].cs});
    end
    // backpressure on the pace-4 instance
    pulse_start(1);
    base = nw[1];
    acc = 0;
    lowq = -1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      vl[1] = acc < 6;
      dd[1] = 8'hA0 + 8'(acc);
      #1;
      if (vl[1] && !rdy[1] && lowq < 0) lowq = acc - (nw[1] - base);
      if (vl[1] && rdy[1]) acc++;
      if (nw[1] - base >= 6) break;
    end
    vl[1] = 1'b0;
    chk("bp_outstanding", 64'(lowq), 64'd4);
    chk("bp_writes", 64'(nw[1] - base), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_addr[%0d]", i), 64'(lad[1][base + i]), 64'(i));
      chk($sformatf("bp_data[%0d]", i), 64'(ldt[1][base + i]), 64'(8'hA0 + 8'(i)));
      if (i > 0) chk($sformatf("bp_gap[%0d]", i), 64'(lcy[1][base + i] - lcy[1][base + i - 1]), 64'd4);
    end
    // restart after three writes of a five-byte stream
    pulse_start(1);
    base = nw[1];
    acc = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      vl[1] = acc < 5;
      dd[1] = 8'hC0 + 8'(acc);
      #1;
      if (vl[1] && rdy[1]) acc++;
      if (nw[1] - base >= 3) break;
    end
    vl[1] = 1'b0;
    chk("rs_three_written", 64'(nw[1] - base), 64'd3);
    chk("rs_csum_before", 64'(cs[1]), 64'h43);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    #1;
    base = nw[1];
    chk("rs_cleared", {ad[1], cs[1], ovr[1]}, 64'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("rs_flushed", 64'(nw[1] - base), 64'd0);
    @(negedge clk);
    vl[1] = 1'b1;
    dd[1] = 8'h77;
    #1;
    chk("rs_ready", 64'(rdy[1]), 64'd1);
    @(negedge clk);
    vl[1] = 1'b0;
    wait_wr(1, base + 1);
    chk("rs_first_write", {lad[1][base], ldt[1][base]}, {17'd0, 8'h77});
    chk("rs_csum_after", 64'(cs[1]), 64'h77);
    // overrun on the 2-byte instance
    pulse_start(2);
    vl[2] = 1'b1;
    dd[2] = 8'h01;
    @(negedge clk);
    dd[2] = 8'h02;
    @(negedge clk);
    vl[2] = 1'b0;
    for (int c = 0; c < 20 && dn[2] !== 1'b1; c++) @(negedge clk);
    #1;
    chk("ov_done", {dn[2], bsy[2], cs[2]}, {1'b1, 1'b0, 8'h03});
    chk("ov_log", {64'(nw[2]), lad[2][0], ldt[2][0], lad[2][1], ldt[2][1]},
        {64'd2, 17'd0, 8'h01, 17'd1, 8'h02});
    @(negedge clk);
    vl[2] = 1'b1;
    dd[2] = 8'hFF;
    #1;
    chk("ov_not_ready", 64'(rdy[2]), 64'd0);
    @(negedge clk);
    vl[2] = 1'b0;
    base = nw[2];
    #1;
    chk("ov_flag", {ovr[2], dn[2]}, 64'b11);
    repeat (3) @(negedge clk);
    #1;
    chk("ov_hold", {64'(nw[2] - base), ovr[2], dn[2], en[2]}, {64'd0, 3'b110});
    pulse_start(2);
    #1;
    chk("ov_cleared", {ovr[2], bsy[2], dn[2]}, 64'b010);
    // async reset with two bytes queued on the pace-4 instance
    pulse_start(1);
    base = nw[1];
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      vl[1] = 1'b1;
      dd[1] = 8'hD0 + 8'(i);
    end
    @(negedge clk);
    vl[1] = 1'b0;
    #1;
    chk("ar_one_written", {64'(nw[1] - base), dt[1]}, {64'd1, 8'hD0});
    #1 rst = 1'b1;
    #1;
    chk("ar_immediate", outs(1), 64'd0);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("ar_no_write", 64'(nw[1] - base), 64'd1);
    chk("ar_hold", outs(1), 64'd0);
    // DL_START together with a valid byte
    @(negedge clk);
    st[0] = 1'b1;
    vl[0] = 1'b1;
    dd[0] = 8'h5A;
    #1;
    chk("sim_not_ready", 64'(rdy[0]), 64'd0);
    @(negedge clk);
    st[0] = 1'b0;
    dd[0] = 8'h3C;
    #1;
    base = nw[0];
    chk("sim_ready", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    vl[0] = 1'b0;
    wait_wr(0, base + 1);
    repeat (3) @(negedge clk);
    #1;
    chk("sim_first", {64'(nw[0] - base), lad[0][base], ldt[0][base]}, {64'd1, 17'd0, 8'h3C});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
